mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Two-master arbiter/sequencer for the single shared memory port.
- Master 0 is the RV32 core's load/store/fetch path. Master 1 is the debug/program-loader port.
- Grants one master at a time, latches its request, and drives the memory side with a wait-state handshake (mem_ready).
- Returns registered read data, an ack pulse and a timeout error to the owner.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT, 16, max cycles in BUSY without mem_ready before abort; 0 disables timeout
TW, $clog2(TIMEOUT+1), timeout counter width (derived, not overridden)

Ports:
clk  in  1  clock, posedge
rst  in  1  reset rst, synchronous, active-high
m0_req  in  1  core request, held until m0_ack
m0_addr  in  AW  core address
m0_wdata  in  DW  core write data
m0_rw  in  1  0=read 1=write
m0_size  in  2  0=none 1=byte 2=hword 3=word
m0_gnt  out  1  core owns bus (core stalls while req && !ack)
m0_ack  out  1  one-cycle completion pulse
m0_err  out  1  valid with m0_ack; timeout or size==0
m0_rdata  out  DW  registered read data, valid with m0_ack
m1_req, m1_addr, m1_wdata, m1_rw, m1_size, m1_gnt, m1_ack, m1_err, m1_rdata: same as m0_* for master 1
mem_req  out  1  memory access active
mem_addr  out  AW  latched address
mem_wdata  out  DW  latched write data
mem_rw  out  1  latched direction
mem_size  out  2  latched size, 0 when mem_req low
mem_ready  in  1  memory completes access this cycle
mem_rdata  in  DW  read data, sampled when mem_ready

Behaviour:
- FSM states: IDLE, BUSY, DONE.
- Reset values: state=IDLE, last=M1 (core wins first tie), all gnt/ack/err=0, rdata=0, mem_req=0, mem_size=0, mem_addr/wdata/rw=0, timeout counter=0.
- IDLE, no req: stay.
- IDLE, any req, at posedge:
  - Pick owner. If only one requests, pick it. If both request, pick the one != last.
  - Latch addr/wdata/rw/size, set last=owner, assert owner gnt, go BUSY.
- BUSY, mem_req=1 (only when latched size!=0):
  - On posedge with mem_ready=1: owner rdata <= mem_rdata (reads) or 0 (writes), go DONE.
  - Otherwise increment counter.
  - If TIMEOUT!=0 and counter reaches TIMEOUT-1 without ready: rdata<=0, err<=1, go DONE.
- BUSY, latched size==0: no memory access (mem_req stays 0); err<=1, go DONE on next posedge.
- DONE (one cycle):
  - Owner ack=1 (err if flagged); gnt drops; mem_req=0; counter clears; return IDLE.
  - DONE does not arbitrate, so reqs seen in DONE are not yet captured. A master still holding req in the cycle after ack is treated as a new request.
- Minimum latency: req sampled edge0 -> BUSY/mem_req cycle1 -> ready in cycle1 -> ack in cycle2. Back-to-back throughput: one access per 3 cycles.
- Request is captured once. Later changes to addr/data/req during BUSY are ignored. A dropped req still completes and acks.
- Non-owner gnt/ack stay 0 for the whole transaction; the non-owner's request waits.
- mem_ready in IDLE/DONE is ignored.
- rst mid-transaction: next cycle IDLE, mem_req=0, no ack issued, last=M1.
- Each mX_rdata holds its value until that master's next ack.

Decomposition:
- Package mem_bus_pkg holds:
  - state enum (IDLE, BUSY, DONE)
  - size constants SZ_NONE=0, SZ_BYTE=1, SZ_HALF=2, SZ_WORD=3
  - master id constants M0=0, M1=1
- Sub-module rr_arbiter2: combinational pick from req[1:0] plus a registered last pointer with an update-enable input. Reused by future peripheral-bus arbitration.

Test Plan:
- Core-only read word at 0x100, mem_ready 1 cycle after mem_req, mem_rdata=0xDEADBEEF -> mem_addr=0x100, mem_size=3, m0_ack pulses cycle2, m0_rdata=0xDEADBEEF, m0_err=0.
- Both req on same edge from reset -> m0 granted first. Both held (re-req after ack) -> grants alternate M0, M1, M0; m1 write 0x55 at 0x200 size=1 shows mem_rw=1, mem_wdata=0x55.
- Memory holds mem_ready low 3 cycles on m1 read -> mem_req/m1_gnt high 4 cycles, m0_req ignored meanwhile, m1_ack after ready, then m0 served.
- TIMEOUT=16, mem_ready never asserts -> m0_ack and m0_err pulse with m0_rdata=0 after 16 BUSY cycles; mem_req drops; FSM IDLE.
- m0_req with size=0 -> no mem_req, m0_ack+m0_err two cycles later.
- rst asserted during BUSY -> IDLE next cycle, mem_req=0, no ack. Then simultaneous reqs -> M0 granted.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory-bus arbiter and its reusable arbitration pieces.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] SZ_NONE = 2'd0;
  localparam logic [1:0] SZ_BYTE = 2'd1;
  localparam logic [1:0] SZ_HALF = 2'd2;
  localparam logic [1:0] SZ_WORD = 2'd3;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin pick. The last-winner pointer only moves when upd is high,
// so the caller decides when a pick is actually consumed.
module rr_arbiter2 import mem_bus_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  output logic       any,
  output logic       pick
);

  logic last;

  // On a tie, the requester that did not win last time gets the bus.
  assign any  = |req;
  assign pick = req[1] & (~req[0] | (last == M0));

  always_ff @(posedge clk) begin
    if (rst)
      last <= M1;
    else if (upd && any)
      last <= pick;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master sequencer for the shared memory port: arbitrates, latches one request,
// runs the mem_ready handshake with optional timeout and returns ack/err/rdata.
module mem_bus_arbiter import mem_bus_pkg::*; #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_rw,
  input  logic [1:0]    m0_size,
  output logic          m0_gnt,
  output logic          m0_ack,
  output logic          m0_err,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_rw,
  input  logic [1:0]    m1_size,
  output logic          m1_gnt,
  output logic          m1_ack,
  output logic          m1_err,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rw,
  output logic [1:0]    mem_size,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = (TW > 0) ? TW : 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          rw;
    logic [1:0]    size;
  } mreq_t;

  mreq_t         req0, req1, cur;
  state_t        state, state_d;
  logic          owner, pick, any, upd, tmo, err_q;
  logic [CW-1:0] cnt;
  logic [DW-1:0] rdata0, rdata1, rd_d;

  assign req0 = {m0_addr, m0_wdata, m0_rw, m0_size};
  assign req1 = {m1_addr, m1_wdata, m1_rw, m1_size};

  rr_arbiter2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .req  ({m1_req, m0_req}),
    .upd  (upd),
    .any  (any),
    .pick (pick)
  );

  assign tmo  = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));
  assign rd_d = ((cur.size != SZ_NONE) && mem_ready && !cur.rw) ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    upd     = 1'b0;
    case (state)
      IDLE: if (any) begin
        state_d = BUSY;
        upd     = 1'b1;
      end
      BUSY: if ((cur.size == SZ_NONE) || mem_ready || tmo) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request is captured once on entry to BUSY; later input changes are not looked at.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur    <= '0;
      owner  <= M0;
      cnt    <= '0;
      err_q  <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt   <= '0;
          err_q <= 1'b0;
          if (any) begin
            cur   <= pick ? req1 : req0;
            owner <= pick;
          end
        end
        BUSY: begin
          if (state_d == DONE) begin
            err_q <= (cur.size == SZ_NONE) | ~mem_ready;
            if (owner == M1) rdata1 <= rd_d;
            else             rdata0 <= rd_d;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          err_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req   = (state == BUSY) && (cur.size != SZ_NONE);
  assign mem_size  = mem_req ? cur.size : SZ_NONE;
  assign mem_addr  = cur.addr;
  assign mem_wdata = cur.wdata;
  assign mem_rw    = cur.rw;

  assign m0_gnt   = (state == BUSY) && (owner == M0);
  assign m1_gnt   = (state == BUSY) && (owner == M1);
  assign m0_ack   = (state == DONE) && (owner == M0);
  assign m1_ack   = (state == DONE) && (owner == M1);
  assign m0_err   = m0_ack & err_q;
  assign m1_err   = m1_ack & err_q;
  assign m0_rdata = rdata0;
  assign m1_rdata = rdata1;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed scenarios plus a randomized run against a transaction-level model of the arbiter.
module tb_mem_bus_arbiter;

  logic        clk, rst;
  logic        m0_req, m0_rw, m0_gnt, m0_ack, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [1:0]  m0_size;
  logic        m1_req, m1_rw, m1_gnt, m1_ack, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [1:0]  m1_size;
  logic        mem_req, mem_rw, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_size;

  int checks = 0;
  int errors = 0;

  // Model state: which master won last, and what each master's rdata should read.
  logic        mdl_last;
  logic [31:0] mdl_rdata [2];
  logic        pend [2];
  logic [31:0] p_addr [2];
  logic [31:0] p_wdata [2];
  logic        p_rw [2];
  logic [1:0]  p_size [2];

  mem_bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rw(m0_rw), .m0_size(m0_size),
    .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rw(m1_rw), .m1_size(m1_size),
    .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw),
    .mem_size(mem_size), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    m0_req = 0; m0_addr = 0; m0_wdata = 0; m0_rw = 0; m0_size = 0;
    m1_req = 0; m1_addr = 0; m1_wdata = 0; m1_rw = 0; m1_size = 0;
    mem_ready = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    rst = 1; @(negedge clk); @(negedge clk); rst = 0;
    mdl_last = 1'b1; mdl_rdata[0] = 0; mdl_rdata[1] = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    do_reset();
    checks++; if ({m0_gnt, m1_gnt, m0_ack, m1_ack, m0_err, m1_err, mem_req, mem_rw} !== 8'h00) begin
      errors++; $display("FAIL reset_ctrl got %b exp 00000000", {m0_gnt, m1_gnt, m0_ack, m1_ack, m0_err, m1_err, mem_req, mem_rw}); end
    checks++; if (mem_size !== 2'd0) begin errors++; $display("FAIL reset_size got %0d exp 0", mem_size); end
    checks++; if ({m0_rdata, m1_rdata} !== 64'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", {m0_rdata, m1_rdata}); end
    checks++; if ({mem_addr, mem_wdata} !== 64'h0) begin errors++; $display("FAIL reset_addr_wdata got %h exp 0", {mem_addr, mem_wdata}); end
  endtask

  task automatic test_core_read();
    m0_req = 1; m0_addr = 32'h100; m0_size = 2'd3; m0_rw = 0;
    mem_ready = 1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if ({mem_req, m0_gnt, m1_gnt, m0_ack} !== 4'b1100) begin
      errors++; $display("FAIL rd_busy got %b exp 1100", {mem_req, m0_gnt, m1_gnt, m0_ack}); end
    checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL rd_addr got %h exp 100", mem_addr); end
    checks++; if (mem_size !== 2'd3 || mem_rw !== 1'b0) begin errors++; $display("FAIL rd_size_rw got %0d/%b exp 3/0", mem_size, mem_rw); end
    @(negedge clk);
    checks++; if ({m0_ack, m0_err, m0_gnt, mem_req} !== 4'b1000) begin
      errors++; $display("FAIL rd_ack got %b exp 1000", {m0_ack, m0_err, m0_gnt, mem_req}); end
    checks++; if (m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h exp deadbeef", m0_rdata); end
    m0_req = 0; mem_ready = 0;
    @(negedge clk);
    checks++; if (m0_ack !== 1'b0 || m0_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rd_ack_pulse got ack=%b rdata=%h exp ack=0 rdata=deadbeef", m0_ack, m0_rdata); end
    mdl_last = 1'b0;
  endtask

  task automatic test_alternate();
    logic own;
    idle_inputs();
    do_reset();
    m0_req = 1; m0_addr = 32'h300; m0_size = 2'd3; m0_rw = 0;
    m1_req = 1; m1_addr = 32'h200; m1_size = 2'd1; m1_rw = 1; m1_wdata = 32'h55;
    mem_ready = 1; mem_rdata = 32'h12345678;
    for (int k = 0; k < 3; k++) begin
      own = ~mdl_last; mdl_last = own;
      @(negedge clk);
      checks++; if ({m1_gnt, m0_gnt} !== (own ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL alt_gnt[%0d] got %b exp %b", k, {m1_gnt, m0_gnt}, own ? 2'b10 : 2'b01); end
      if (own) begin
        checks++; if ({mem_rw, mem_size, mem_addr, mem_wdata} !== {1'b1, 2'd1, 32'h200, 32'h55}) begin
          errors++; $display("FAIL alt_m1_write got rw=%b sz=%0d a=%h d=%h exp rw=1 sz=1 a=200 d=55", mem_rw, mem_size, mem_addr, mem_wdata); end
      end else begin
        checks++; if ({mem_rw, mem_addr} !== {1'b0, 32'h300}) begin
          errors++; $display("FAIL alt_m0_read got rw=%b a=%h exp rw=0 a=300", mem_rw, mem_addr); end
      end
      @(negedge clk);
      checks++; if ({m1_ack, m0_ack} !== (own ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL alt_ack[%0d] got %b exp %b", k, {m1_ack, m0_ack}, own ? 2'b10 : 2'b01); end
      if (own) begin
        checks++; if (m1_rdata !== 32'h0) begin errors++; $display("FAIL alt_wr_rdata got %h exp 0", m1_rdata); end
      end else begin
        checks++; if (m0_rdata !== 32'h12345678) begin errors++; $display("FAIL alt_rd_rdata got %h exp 12345678", m0_rdata); end
      end
      @(negedge clk);
    end
    m0_req = 0; m1_req = 0; mem_ready = 0;
  endtask

  task automatic test_wait_states();
    m1_req = 1; m1_addr = 32'h240; m1_size = 2'd3; m1_rw = 0; mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin m0_req = 1; m0_addr = 32'h104; m0_size = 2'd2; m0_rw = 0; end
      checks++; if ({mem_req, m1_gnt, m0_gnt, m1_ack} !== 4'b1100) begin
        errors++; $display("FAIL ws_busy[%0d] got %b exp 1100", i, {mem_req, m1_gnt, m0_gnt, m1_ack}); end
      if (i == 3) begin mem_ready = 1; mem_rdata = 32'hCAFE0001; end
    end
    @(negedge clk);
    checks++; if ({m1_ack, m0_ack, mem_req, m1_rdata} !== {3'b100, 32'hCAFE0001}) begin
      errors++; $display("FAIL ws_ack got %b rdata=%h exp 100 rdata=cafe0001", {m1_ack, m0_ack, mem_req}, m1_rdata); end
    m1_req = 0; mem_ready = 0;
    @(negedge clk);
    @(negedge clk);
    checks++; if ({m0_gnt, mem_addr, mem_size} !== {1'b1, 32'h104, 2'd2}) begin
      errors++; $display("FAIL ws_m0_next got gnt=%b a=%h sz=%0d exp gnt=1 a=104 sz=2", m0_gnt, mem_addr, mem_size); end
    mem_ready = 1; mem_rdata = 32'h0BAD0002;
    @(negedge clk);
    checks++; if (m0_ack !== 1'b1 || m0_rdata !== 32'h0BAD0002) begin
      errors++; $display("FAIL ws_m0_ack got ack=%b rdata=%h exp ack=1 rdata=0bad0002", m0_ack, m0_rdata); end
    m0_req = 0; mem_ready = 0;
    @(negedge clk);
    mdl_last = 1'b0;
  endtask

  task automatic test_timeout();
    int  n = 0;
    logic seen = 0;
    m0_req = 1; m0_addr = 32'h180; m0_size = 2'd3; m0_rw = 0; mem_ready = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (m0_ack) seen = 1;
      else if (mem_req) n++;
    end
    m0_req = 0;
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL tmo_ack_seen got 0 exp 1 within 40 cycles"); end
    checks++; if (n != 16) begin errors++; $display("FAIL tmo_busy_cycles got %0d exp 16", n); end
    checks++; if ({m0_err, mem_req, m0_rdata} !== {2'b10, 32'h0}) begin
      errors++; $display("FAIL tmo_err got err=%b mem_req=%b rdata=%h exp 1/0/0", m0_err, mem_req, m0_rdata); end
    @(negedge clk);
    checks++; if ({m0_ack, m0_gnt, mem_req} !== 3'b000) begin
      errors++; $display("FAIL tmo_idle got %b exp 000", {m0_ack, m0_gnt, mem_req}); end
  endtask

  task automatic test_size0();
    m0_req = 1; m0_addr = 32'h44; m0_size = 2'd0; m0_rw = 0; mem_ready = 1;
    @(negedge clk);
    checks++; if ({mem_req, mem_size, m0_ack} !== 4'b0000) begin
      errors++; $display("FAIL sz0_busy got %b exp 0000", {mem_req, mem_size, m0_ack}); end
    @(negedge clk);
    checks++; if ({m0_ack, m0_err} !== 2'b11) begin errors++; $display("FAIL sz0_ack_err got %b exp 11", {m0_ack, m0_err}); end
    m0_req = 0; mem_ready = 0;
    @(negedge clk);
    mdl_last = 1'b0;
  endtask

  task automatic test_reset_mid();
    m0_req = 1; m0_addr = 32'h1C0; m0_size = 2'd3; m0_rw = 0; mem_ready = 0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rstm_busy got %b exp 1", mem_req); end
    rst = 1; m0_req = 0;
    @(negedge clk);
    checks++; if ({mem_req, m0_gnt, m0_ack, m0_rdata} !== {3'b000, 32'h0}) begin
      errors++; $display("FAIL rstm_idle got %b rdata=%h exp 000 rdata=0", {mem_req, m0_gnt, m0_ack}, m0_rdata); end
    rst = 0;
    @(negedge clk);
    checks++; if ({m0_ack, m1_ack} !== 2'b00) begin errors++; $display("FAIL rstm_no_ack got %b exp 00", {m0_ack, m1_ack}); end
    m0_req = 1; m0_addr = 32'h10; m0_size = 2'd3;
    m1_req = 1; m1_addr = 32'h20; m1_size = 2'd3; m1_rw = 0;
    mem_ready = 1; mem_rdata = 32'h77;
    @(negedge clk);
    checks++; if ({m1_gnt, m0_gnt, mem_addr} !== {2'b01, 32'h10}) begin
      errors++; $display("FAIL rstm_m0_first got gnt=%b a=%h exp 01 a=10", {m1_gnt, m0_gnt}, mem_addr); end
    @(negedge clk);
    m0_req = 0; m1_req = 0; mem_ready = 0;
    @(negedge clk);
  endtask

  task automatic new_req(input int m);
    pend[m] = 1; p_addr[m] = $urandom; p_wdata[m] = $urandom;
    p_rw[m] = 1'($urandom_range(0, 1)); p_size[m] = 2'($urandom_range(1, 3));
  endtask

  task automatic test_random();
    logic        own, in_done;
    logic [31:0] exp_rd;
    int          waits;
    idle_inputs();
    do_reset();
    pend[0] = 0; pend[1] = 0; in_done = 0;
    for (int it = 0; it < 80; it++) begin
      for (int m = 0; m < 2; m++) if (!pend[m] && $urandom_range(0, 2) != 0) new_req(m);
      if (!pend[0] && !pend[1]) new_req(int'($urandom_range(0, 1)));
      m0_req = pend[0]; m0_addr = p_addr[0]; m0_wdata = p_wdata[0]; m0_rw = p_rw[0]; m0_size = p_size[0];
      m1_req = pend[1]; m1_addr = p_addr[1]; m1_wdata = p_wdata[1]; m1_rw = p_rw[1]; m1_size = p_size[1];
      if (in_done) begin
        @(negedge clk);
        checks++; if ({m0_gnt, m1_gnt, mem_req, mem_size} !== 5'b0) begin
          errors++; $display("FAIL rnd_idle[%0d] got %b exp 00000", it, {m0_gnt, m1_gnt, mem_req, mem_size}); end
        mem_ready = 1'($urandom_range(0, 1));
      end
      own = (pend[0] && pend[1]) ? ~mdl_last : pend[1];
      mdl_last = own;
      waits = int'($urandom_range(0, 3));
      exp_rd = 0;
      for (int w = 0; w <= waits; w++) begin
        @(negedge clk);
        checks++; if ({m1_gnt, m0_gnt, mem_req, m1_ack, m0_ack} !== {(own ? 2'b10 : 2'b01), 3'b100}) begin
          errors++; $display("FAIL rnd_busy[%0d.%0d] got %b exp %b", it, w, {m1_gnt, m0_gnt, mem_req, m1_ack, m0_ack}, {(own ? 2'b10 : 2'b01), 3'b100}); end
        checks++; if ({mem_addr, mem_wdata, mem_rw, mem_size} !== {p_addr[own], p_wdata[own], p_rw[own], p_size[own]}) begin
          errors++; $display("FAIL rnd_latch[%0d] got a=%h d=%h rw=%b sz=%0d exp a=%h d=%h rw=%b sz=%0d", it,
                             mem_addr, mem_wdata, mem_rw, mem_size, p_addr[own], p_wdata[own], p_rw[own], p_size[own]); end
        // The owner is free to change or drop its inputs once captured.
        if (own) begin m1_addr = $urandom; m1_wdata = $urandom; m1_size = 2'($urandom_range(0, 3)); m1_req = 1'($urandom_range(0, 1)); end
        else     begin m0_addr = $urandom; m0_wdata = $urandom; m0_size = 2'($urandom_range(0, 3)); m0_req = 1'($urandom_range(0, 1)); end
        mem_ready = (w == waits);
        mem_rdata = $urandom;
        if (w == waits) exp_rd = p_rw[own] ? 32'h0 : mem_rdata;
      end
      @(negedge clk);
      checks++; if ({m1_ack, m0_ack, m1_err, m0_err, m1_gnt, m0_gnt} !== {(own ? 2'b10 : 2'b01), 4'b0}) begin
        errors++; $display("FAIL rnd_ack[%0d] got %b exp %b", it, {m1_ack, m0_ack, m1_err, m0_err, m1_gnt, m0_gnt}, {(own ? 2'b10 : 2'b01), 4'b0}); end
      mdl_rdata[own] = exp_rd;
      checks++; if ({m0_rdata, m1_rdata} !== {mdl_rdata[0], mdl_rdata[1]}) begin
        errors++; $display("FAIL rnd_rdata[%0d] got %h/%h exp %h/%h", it, m0_rdata, m1_rdata, mdl_rdata[0], mdl_rdata[1]); end
      pend[own] = 0;
      if (own) m1_req = 0; else m0_req = 0;
      mem_ready = 1'($urandom_range(0, 1));
      in_done = 1;
    end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_core_read();
    test_alternate();
    test_wait_states();
    test_timeout();
    test_size0();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
